// File: rtl/xorshift32_pkg.sv
// Shared constants, word type and the XorShift32 step function for the PRNG block.
// Used by xorshift32_rng and xorshift32_range_map.
package xorshift32_pkg;

    typedef logic [31:0] word_t;

    localparam word_t DEFAULT_SEED = 32'd42;
    localparam word_t DEFAULT_LOW  = 32'd0;
    localparam word_t DEFAULT_HIGH = 32'd100;

    // Overflow bits fall off the 32-bit word by construction.
    function automatic word_t xorshift32_step(input word_t x);
        word_t t;
        t = x ^ (x << 13);
        t = t ^ (t >> 17);
        t = t ^ (t << 5);
        return t;
    endfunction

endpackage

// File: rtl/xorshift32_range_map.sv
// Combinational mapping of a raw word into [low, high): low + raw mod (high - low).
// Instantiated by xorshift32_rng only when XORSHIFT32_RANGE_EN is defined.
module xorshift32_range_map
    import xorshift32_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [31:0] low,
    input  logic [31:0] high,
    output logic [31:0] mapped
);

    logic [31:0] span;

    // The range registers never hold high <= low; the zero guard keeps the divider defined.
    always_comb begin
        span = high - low;
        if (span == 32'd0) begin
            mapped = low;
        end else begin
            mapped = low + (raw % span);
        end
    end

endmodule

// File: rtl/xorshift32_rng.sv
// XorShift32 generator with registered raw and range-mapped outputs.
// Macro XORSHIFT32_RANGE_EN enables the range registers and modulo mapping.
module xorshift32_rng
    import xorshift32_pkg::*;
(
    input  logic        clk,
    input  logic        prng_reset,
    input  logic        aresetn,
    input  logic        enable,
    input  logic        update_seed,
    input  logic [31:0] new_seed,
    input  logic        update_range,
    input  logic [31:0] new_low,
    input  logic [31:0] new_high,
    output logic [31:0] random_raw,
    output logic [31:0] random_in_range,
    output logic        valid
);

    logic  rst;
    word_t state_q, state_d;
    word_t raw_q, raw_d;
    logic  valid_q, valid_d;
    word_t next_state;

    assign rst        = prng_reset | ~aresetn;
    assign next_state = xorshift32_step(state_q);

`ifdef XORSHIFT32_RANGE_EN
    word_t low_q, low_d;
    word_t high_q, high_d;
    word_t in_range_q, in_range_d;
    word_t mapped;

    xorshift32_range_map u_range_map (
        .raw    (next_state),
        .low    (low_q),
        .high   (high_q),
        .mapped (mapped)
    );

    // Invalid range collapses to the single value new_low.
    always_comb begin
        low_d      = low_q;
        high_d     = high_q;
        in_range_d = in_range_q;
        if (update_range) begin
            low_d  = new_low;
            high_d = (new_high > new_low) ? new_high : new_low + 32'd1;
        end
        if (!update_seed && enable) begin
            in_range_d = mapped;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            low_q      <= DEFAULT_LOW;
            high_q     <= DEFAULT_HIGH;
            in_range_q <= '0;
        end else begin
            low_q      <= low_d;
            high_q     <= high_d;
            in_range_q <= in_range_d;
        end
    end

    assign random_in_range = in_range_q;
`else
    logic unused_range_inputs;
    assign unused_range_inputs = ^{update_range, new_low, new_high};
    assign random_in_range     = raw_q;
`endif

    // A seed load wins over a step in the same cycle.
    always_comb begin
        state_d = state_q;
        raw_d   = raw_q;
        valid_d = valid_q;
        if (update_seed) begin
            state_d = (new_seed == 32'd0) ? DEFAULT_SEED : new_seed;
        end else if (enable) begin
            state_d = next_state;
            raw_d   = next_state;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DEFAULT_SEED;
            raw_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            raw_q   <= raw_d;
            valid_q <= valid_d;
        end
    end

    assign random_raw = raw_q;
    assign valid      = valid_q;

endmodule

// File: tb/tb_xorshift32_rng.sv
// Directed self-checking bench for xorshift32_rng; expectations follow XORSHIFT32_RANGE_EN.
module tb_xorshift32_rng;

    logic        clk = 1'b0;
    logic        prng_reset = 1'b1;
    logic        aresetn = 1'b1;
    logic        enable = 1'b0;
    logic        update_seed = 1'b0;
    logic [31:0] new_seed = '0;
    logic        update_range = 1'b0;
    logic [31:0] new_low = '0;
    logic [31:0] new_high = '0;
    logic [31:0] random_raw;
    logic [31:0] random_in_range;
    logic        valid;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] m_x, m_low, m_high, m_raw, m_inr;
    logic [31:0] def_seq [0:5];
    logic [31:0] prev;

    xorshift32_rng dut (
        .clk             (clk),
        .prng_reset      (prng_reset),
        .aresetn         (aresetn),
        .enable          (enable),
        .update_seed     (update_seed),
        .new_seed        (new_seed),
        .update_range    (update_range),
        .new_low         (new_low),
        .new_high        (new_high),
        .random_raw      (random_raw),
        .random_in_range (random_in_range),
        .valid           (valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] m_step(input logic [31:0] x);
        logic [31:0] y;
        y = x ^ {x[18:0], 13'd0};
        y = y ^ {17'd0, y[31:17]};
        y = y ^ {y[26:0], 5'd0};
        return y;
    endfunction

    function automatic logic [31:0] m_map(input logic [31:0] r);
`ifdef XORSHIFT32_RANGE_EN
        return m_low + (r % (m_high - m_low));
`else
        return r;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".raw"}, random_raw, m_raw);
        check({tag, ".inr"}, random_in_range, m_inr);
    endtask

    // One enabled cycle, model advanced alongside.
    task automatic step_once();
        enable = 1'b1;
        tick();
        enable = 1'b0;
        m_x   = m_step(m_x);
        m_raw = m_x;
        m_inr = m_map(m_x);
    endtask

    task automatic set_range(input logic [31:0] lo, input logic [31:0] hi);
        update_range = 1'b1;
        new_low  = lo;
        new_high = hi;
        tick();
        update_range = 1'b0;
`ifdef XORSHIFT32_RANGE_EN
        m_low  = lo;
        m_high = (hi > lo) ? hi : lo + 32'd1;
`endif
    endtask

    task automatic set_seed(input logic [31:0] s);
        update_seed = 1'b1;
        new_seed = s;
        tick();
        update_seed = 1'b0;
        m_x = (s == 32'd0) ? 32'd42 : s;
    endtask

    initial begin
        m_x = 32'd42; m_low = 32'd0; m_high = 32'd100; m_raw = '0; m_inr = '0;
        def_seq[0] = m_step(32'd42);
        for (int i = 1; i < 6; i++) def_seq[i] = m_step(def_seq[i-1]);

        tick(); tick();
        prng_reset = 1'b0;
        check("reset.raw", random_raw, 32'h0);
        check("reset.inr", random_in_range, 32'h0);
        check("reset.valid", {31'd0, valid}, 32'd0);

        step_once();
        check("first.raw_const", random_raw, 32'h00AD4528);
`ifdef XORSHIFT32_RANGE_EN
        check("first.inr_const", random_in_range, 32'd32);
`else
        check("first.inr_mirror", random_in_range, 32'h00AD4528);
`endif
        check("first.valid", {31'd0, valid}, 32'd1);

        step_once();
        check("second.raw_const", random_raw, 32'hA90A34AC);
        check_outputs("second");

        // Hold without enable
        tick(); tick();
        check_outputs("hold");
        check("hold.valid", {31'd0, valid}, 32'd1);

        for (int i = 0; i < 9; i++) begin
            prev = random_raw;
            step_once();
            check_outputs("run");
            check("run.changes", {31'd0, random_raw != prev}, 32'd1);
`ifdef XORSHIFT32_RANGE_EN
            check("run.below100", {31'd0, random_in_range < 32'd100}, 32'd1);
`endif
        end

        set_seed(32'hDEADBEEF);
        check_outputs("seed.hold");
        check("seed.valid_hold", {31'd0, valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            step_once();
            check_outputs("deadbeef");
            check("deadbeef.differs", {31'd0, random_raw != def_seq[i]}, 32'd1);
        end

        set_seed(32'd0);
        step_once();
        check("seed0.raw_const", random_raw, 32'h00AD4528);

        set_range(32'd50, 32'd150);
        for (int i = 0; i < 10; i++) begin
            step_once();
            check_outputs("r50_150");
`ifdef XORSHIFT32_RANGE_EN
            check("r50_150.bounds",
                  {31'd0, (random_in_range >= 32'd50) && (random_in_range < 32'd150)}, 32'd1);
`endif
        end

        set_range(32'd100, 32'd50);
        step_once();
        check_outputs("inverted");
`ifdef XORSHIFT32_RANGE_EN
        check("inverted.const", random_in_range, 32'd100);
`endif

        set_range(32'd42, 32'd43);
        step_once();
        check_outputs("single");
`ifdef XORSHIFT32_RANGE_EN
        check("single.const", random_in_range, 32'd42);
`endif

        set_range(32'd0, 32'd1000000);
        step_once();
        check_outputs("wide");
`ifdef XORSHIFT32_RANGE_EN
        check("wide.bound", {31'd0, random_in_range < 32'd1000000}, 32'd1);
`endif

        // Range update alongside enable: this step still maps with [0,1000000)
        update_range = 1'b1; new_low = 32'd0; new_high = 32'd10;
        step_once();
        update_range = 1'b0;
        check_outputs("range_same_cycle");
`ifdef XORSHIFT32_RANGE_EN
        m_low = 32'd0; m_high = 32'd10;
`endif
        step_once();
        check_outputs("range_next_cycle");

        // Reset with a pending step and seed update discards both
        prng_reset = 1'b1; enable = 1'b1; update_seed = 1'b1; new_seed = 32'h1;
        tick();
        prng_reset = 1'b0; enable = 1'b0; update_seed = 1'b0;
        m_x = 32'd42; m_low = 32'd0; m_high = 32'd100; m_raw = '0; m_inr = '0;
        check_outputs("prng_reset");
        check("prng_reset.valid", {31'd0, valid}, 32'd0);
        step_once();
        check("after_reset.raw", random_raw, 32'h00AD4528);
        check_outputs("after_reset");

        step_once();
        aresetn = 1'b0;
        tick();
        aresetn = 1'b1;
        m_x = 32'd42; m_raw = '0; m_inr = '0;
        check_outputs("aresetn");
        check("aresetn.valid", {31'd0, valid}, 32'd0);

        // Seed load wins over a coincident enable
        step_once();
        update_seed = 1'b1; new_seed = 32'h12345678; enable = 1'b1;
        tick();
        update_seed = 1'b0; enable = 1'b0;
        m_x = 32'h12345678;
        check_outputs("seed_vs_enable.hold");
        step_once();
        check("seed_vs_enable.step", random_raw, m_step(32'h12345678));
        check_outputs("seed_vs_enable");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
